// File: rtl/blok_pkg.sv
// blok_pkg: shared constants for the blok execution stage.
// Holds datapath width, opcode map and FSM state encoding.
package blok_pkg;

   localparam int W         = 8;
   localparam int MUL_STEPS = W;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_INC = 4'h1;
   localparam logic [3:0] OP_DEC = 4'h2;
   localparam logic [3:0] OP_NOT = 4'h3;
   localparam logic [3:0] OP_SHL = 4'h4;
   localparam logic [3:0] OP_SHR = 4'h5;
   localparam logic [3:0] OP_ADD = 4'h8;
   localparam logic [3:0] OP_NEG = 4'h9;
   localparam logic [3:0] OP_SUB = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;
   localparam logic [3:0] OP_AND = 4'hC;
   localparam logic [3:0] OP_XOR = 4'hD;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_WB   = 2'd2
   } state_t;

endpackage

// File: rtl/blok_mul_seq.sv
// blok_mul_seq: shift-add multiplier, one partial product per step.
// Ports: c/rst clock+async reset; load captures a,b; step advances;
// prod is the accumulator including the current step's addition;
// cnt_done flags that the current step is the last one.
module blok_mul_seq
   import blok_pkg::*;
(
   input  logic           c,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] prod,
   output logic           cnt_done
);

   localparam int CW = $clog2(MUL_STEPS);
   localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;

   // prod already folds in this step's term so the final
   // result can be registered on the same edge as the last step
   assign prod     = acc + (mplier[0] ? mcand : '0);
   assign cnt_done = (cnt == LAST);

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{W{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/blok_alu.sv
// blok_alu: execution stage behind the register file; single-cycle ops
// plus a multi-cycle MUL. Ports: c, rst, start, k (instr), x, y (operands);
// d_bus/wreg write-back, busy/done handshake, fz/fc flags.
module blok_alu
   import blok_pkg::*;
(
   input  logic         c,
   input  logic         rst,
   input  logic         start,
   input  logic [15:0]  k,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] d_bus,
   output logic         wreg,
   output logic         busy,
   output logic         done,
   output logic         fz,
   output logic         fc
);

   logic [3:0]     op;
   logic [W:0]     ext;
   logic [W-1:0]   res;
   logic           cf;
   logic           wr;
   logic           is_mul;

   state_t         state;
   state_t         state_nx;
   logic           load;
   logic           step;
   logic           fin_op;
   logic           fin_nop;
   logic           fin_mul;

   logic [2*W-1:0] prod;
   logic           cnt_done;
   logic           unused_k;

   assign op       = k[15:12];
   assign unused_k = ^k[11:W];
   assign busy     = (state == S_MUL);

   // single-cycle result and flag; ext carries the borrow/carry bit
   always_comb begin
      ext    = '0;
      res    = '0;
      cf     = 1'b0;
      wr     = 1'b1;
      is_mul = 1'b0;
      unique case (op)
         OP_LDI: res = k[W-1:0];
         OP_INC: begin
            ext = {1'b0, x} + (W+1)'(1);
            res = ext[W-1:0];
            cf  = ext[W];
         end
         OP_DEC: begin
            ext = {1'b0, x} - (W+1)'(1);
            res = ext[W-1:0];
            cf  = ext[W];
         end
         OP_NOT: res = ~x;
         OP_SHL: begin
            res = {x[W-2:0], 1'b0};
            cf  = x[W-1];
         end
         OP_SHR: begin
            res = {1'b0, x[W-1:1]};
            cf  = x[0];
         end
         OP_ADD: begin
            ext = {1'b0, x} + {1'b0, y};
            res = ext[W-1:0];
            cf  = ext[W];
         end
         OP_NEG: begin
            ext = '0 - {1'b0, x};
            res = ext[W-1:0];
            cf  = ext[W];
         end
         OP_SUB: begin
            ext = {1'b0, x} - {1'b0, y};
            res = ext[W-1:0];
            cf  = ext[W];
         end
         OP_MUL: begin
            is_mul = 1'b1;
            wr     = 1'b0;
         end
         OP_AND: res = x & y;
         OP_XOR: res = x ^ y;
         default: wr = 1'b0;
      endcase
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // WB accepts a new start exactly like IDLE
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      fin_op   = 1'b0;
      fin_nop  = 1'b0;
      fin_mul  = 1'b0;
      unique case (state)
         S_MUL: begin
            step = 1'b1;
            if (cnt_done) begin
               fin_mul  = 1'b1;
               state_nx = S_WB;
            end
         end
         default: begin
            state_nx = S_IDLE;
            if (start) begin
               if (is_mul) begin
                  load     = 1'b1;
                  state_nx = S_MUL;
               end else if (wr) begin
                  fin_op = 1'b1;
               end else begin
                  fin_nop = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         d_bus <= '0;
         wreg  <= 1'b0;
         done  <= 1'b0;
         fz    <= 1'b0;
         fc    <= 1'b0;
      end else begin
         wreg <= fin_op | fin_mul;
         done <= fin_op | fin_mul | fin_nop;
         if (fin_op) begin
            d_bus <= res;
            fz    <= (res == '0);
            fc    <= cf;
         end else if (fin_mul) begin
            d_bus <= prod[W-1:0];
            fz    <= (prod[W-1:0] == '0);
            fc    <= |prod[2*W-1:W];
         end
      end
   end

   blok_mul_seq u_mul (
      .c        (c),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .a        (x),
      .b        (y),
      .prod     (prod),
      .cnt_done (cnt_done)
   );

endmodule
